// File: rtl/stream_pkg.sv
// Shared defaults and helpers for the stream path (arbiter -> stream_fifo).
package stream_pkg;

  localparam int BIT_DEPTH_DEF = 8;
  localparam int DEPTH_DEF     = 4;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO behind the arbiter. The arbiter cannot be
// stalled, so words arriving while the FIFO is full are dropped.
// Optional sticky overflow flag: define STREAM_FIFO_OVF_EN to add port ovf.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int BIT_DEPTH = BIT_DEPTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [BIT_DEPTH-1:0]       t_data_i,
  input  logic                       t_valid_i,
  output logic                       t_ready_o,
  output logic [BIT_DEPTH-1:0]       t_data_o,
  output logic                       t_valid_o,
  input  logic                       t_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef STREAM_FIFO_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [BIT_DEPTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 empty, full, push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign t_valid_o = !empty;
  assign t_data_o  = mem[rd_ptr[IW-1:0]];
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop       = t_valid_o && t_ready_i;
  assign push      = t_valid_i && (!full || pop);
  assign t_ready_o = !full || t_ready_i;
  // Modular difference of the wrap-extended pointers gives 0..DEPTH.
  assign count     = CW'(wr_ptr - rd_ptr);

  // Pointer update; reset empties the queue immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since valid is derived from pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= t_data_i;
  end

`ifdef STREAM_FIFO_OVF_EN
  // Sticky flag: set after any cycle where an incoming word was discarded.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                    ovf <= 1'b0;
    else if (t_valid_i && !push) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: vector table, hand sequences and a
// queue-based random reference.
module tb_stream_fifo;
  import stream_pkg::*;

  localparam int BW = BIT_DEPTH_DEF;
  localparam int D  = DEPTH_DEF;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          arst;
  logic [BW-1:0] t_data_i;
  logic          t_valid_i;
  logic          t_ready_o;
  logic [BW-1:0] t_data_o;
  logic          t_valid_o;
  logic          t_ready_i;
  logic [CW-1:0] count;
`ifdef STREAM_FIFO_OVF_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  stream_fifo #(.BIT_DEPTH(BW), .DEPTH(D)) dut (
    .clk(clk), .arst(arst),
    .t_data_i(t_data_i), .t_valid_i(t_valid_i), .t_ready_o(t_ready_o),
    .t_data_o(t_data_o), .t_valid_o(t_valid_o), .t_ready_i(t_ready_i),
    .count(count)
`ifdef STREAM_FIFO_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [BW-1:0] d;
    logic          r;
    logic          e_valid;
    logic [BW-1:0] e_data;
    int            e_count;
    logic          e_rdy;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs; caller then settles and checks pre-edge outputs.
  task automatic drive(input logic v, input logic [BW-1:0] d, input logic r);
    t_valid_i = v; t_data_i = d; t_ready_i = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst = 1'b1; t_valid_i = 0; t_data_i = '0; t_ready_i = 0;
    #3 arst = 1'b0;
    tick();
  endtask

  task automatic push_n(input logic [BW-1:0] d);
    drive(1'b1, d, 1'b0); tick();
  endtask

  // Model state for the random phase
  logic [BW-1:0] q[$];
  logic          ovf_m;

  initial begin
    arst = 1'b1; t_valid_i = 0; t_data_i = '0; t_ready_i = 0;
    #3 arst = 1'b0;
    #1;
    chk("rst_valid", t_valid_o, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", t_ready_o, 1);
`ifdef STREAM_FIFO_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    tick();

    // Single word, then fill to DEPTH and drain in order
    tbl[0]  = '{1, 7,  0, 0, 0,  0, 1};
    tbl[1]  = '{0, 0,  0, 1, 7,  1, 1};
    tbl[2]  = '{0, 0,  1, 1, 7,  1, 1};
    tbl[3]  = '{0, 0,  0, 0, 0,  0, 1};
    tbl[4]  = '{1, 7,  0, 0, 0,  0, 1};
    tbl[5]  = '{1, 15, 0, 1, 7,  1, 1};
    tbl[6]  = '{1, 3,  0, 1, 7,  2, 1};
    tbl[7]  = '{1, 9,  0, 1, 7,  3, 1};
    tbl[8]  = '{0, 0,  0, 1, 7,  4, 0};
    tbl[9]  = '{0, 0,  1, 1, 7,  4, 1};
    tbl[10] = '{0, 0,  1, 1, 15, 3, 1};
    tbl[11] = '{0, 0,  1, 1, 3,  2, 1};
    tbl[12] = '{0, 0,  1, 1, 9,  1, 1};
    tbl[13] = '{0, 0,  0, 0, 0,  0, 1};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), t_valid_o, tbl[i].e_valid);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_count);
      chk($sformatf("vec%0d_rdy", i), t_ready_o, tbl[i].e_rdy);
      if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), t_data_o, tbl[i].e_data);
      tick();
    end

    // Full pass-through: pop and push in the same cycle, no drop
    push_n(7); push_n(15); push_n(3); push_n(9);
    drive(1'b1, 5, 1'b1);
    chk("pt_rdy", t_ready_o, 1);
    tick();
    drive(1'b0, 0, 1'b0);
    chk("pt_count", count, 4);
    chk("pt_head", t_data_o, 15);
`ifdef STREAM_FIFO_OVF_EN
    chk("pt_ovf", ovf, 0);
`endif
    begin
      logic [BW-1:0] exp_pt [4];
      exp_pt = '{15, 3, 9, 5};
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 0, 1'b1);
        chk($sformatf("pt_drain%0d", i), t_data_o, exp_pt[i]);
        tick();
      end
    end
    drive(1'b0, 0, 1'b0);
    chk("pt_empty", t_valid_o, 0);

    // Overflow: a push into a full FIFO with no pop is dropped
    push_n(7); push_n(15); push_n(3); push_n(9);
    drive(1'b1, 21, 1'b0);
    chk("ov_rdy", t_ready_o, 0);
    tick();
    drive(1'b0, 0, 1'b0);
    chk("ov_count", count, 4);
`ifdef STREAM_FIFO_OVF_EN
    chk("ov_flag", ovf, 1);
`endif
    tick();
`ifdef STREAM_FIFO_OVF_EN
    chk("ov_sticky", ovf, 1);
`endif
    begin
      logic [BW-1:0] exp_ov [4];
      exp_ov = '{7, 15, 3, 9};
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 0, 1'b1);
        chk($sformatf("ov_drain%0d", i), t_data_o, exp_ov[i]);
        tick();
      end
    end
    drive(1'b0, 0, 1'b0);
    chk("ov_empty", t_valid_o, 0);
`ifdef STREAM_FIFO_OVF_EN
    chk("ov_hold", ovf, 1);
`endif

    // Random traffic against a queue model (includes wrap and 1 word/cycle runs)
    do_reset();
    q.delete(); ovf_m = 0;
    for (int c = 0; c < 600; c++) begin
      logic v, r, pop_m, push_m;
      logic [BW-1:0] d;
      if (c < 12) begin v = 1; r = (c > 0); end  // sustained streaming at start
      else begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 2) != 0); end
      d = BW'($urandom);
      drive(v, d, r);
      chk("rnd_valid", t_valid_o, q.size() != 0);
      chk("rnd_count", count, q.size());
      chk("rnd_rdy", t_ready_o, (q.size() < D) || r);
      if (q.size() != 0) chk("rnd_data", t_data_o, q[0]);
`ifdef STREAM_FIFO_OVF_EN
      chk("rnd_ovf", ovf, ovf_m);
`endif
      pop_m  = (q.size() != 0) && r;
      push_m = v && ((q.size() < D) || pop_m);
      if (v && !push_m) ovf_m = 1;
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(d);
      tick();
    end

    // Mid-operation asynchronous reset with two words queued
    do_reset();
    push_n(11); push_n(12);
    drive(1'b0, 0, 1'b0);
    chk("mr_count", count, 2);
    #2 arst = 1'b1;
    #1;
    chk("mr_valid", t_valid_o, 0);
    chk("mr_count0", count, 0);
    chk("mr_rdy", t_ready_o, 1);
    arst = 1'b0;
    tick();
    chk("mr_after", t_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
